// File: rtl/linha_pkg.sv
// Shared constants for the line-number 7-segment display path.
// Pattern bus order is {seg_a..seg_g}, active low.
package linha_pkg;

   localparam int SEG_W = 7;

   localparam logic [6:0] PAT_0     = 7'b1001111;
   localparam logic [6:0] PAT_1     = 7'b0010010;
   localparam logic [6:0] PAT_2     = 7'b0000110;
   localparam logic [6:0] PAT_3     = 7'b1001100;
   localparam logic [6:0] PAT_4     = 7'b0100100;
   localparam logic [6:0] PAT_5     = 7'b0100000;
   localparam logic [6:0] PAT_6     = 7'b0001111;
   localparam logic [6:0] PAT_7     = 7'b0000000;
   localparam logic [6:0] PAT_BLANK = 7'b1111111;

   typedef enum logic {
      ESPERA  = 1'b0,
      TRAVADO = 1'b1
   } estado_t;

   // Returns {hit, code}; hit = 0 for blank and unknown patterns.
   function automatic logic [3:0] pat_to_code(input logic [6:0] p);
      logic [3:0] r;
      r = 4'b0000;
      case (p)
         PAT_0:   r = 4'b1000;
         PAT_1:   r = 4'b1001;
         PAT_2:   r = 4'b1010;
         PAT_3:   r = 4'b1011;
         PAT_4:   r = 4'b1100;
         PAT_5:   r = 4'b1101;
         PAT_6:   r = 4'b1110;
         PAT_7:   r = 4'b1111;
         default: r = 4'b0000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Reset value is a parameter so idle lines can reset to their inactive level.
module sincronizador_2ff #(
   parameter int                WIDTH   = 1,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sync1;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= RST_VAL;
         q     <= RST_VAL;
      end else begin
         sync1 <= d;
         q     <= sync1;
      end
   end

endmodule

// File: rtl/cod_numero_linha.sv
// 7-segment read-back: debounces the segment lines and recovers
// the 3-bit line code, flagging stable unknown patterns as errors.
module cod_numero_linha
   import linha_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic seg_a,
   input  logic seg_b,
   input  logic seg_c,
   input  logic seg_d,
   input  logic seg_e,
   input  logic seg_f,
   input  logic seg_g,
   output logic A,
   output logic B,
   output logic C,
   output logic valido,
   output logic erro
);

   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

   logic [6:0] p;
   logic [6:0] sync2;
   logic [6:0] cand;
   logic [7:0] cnt;
   logic [3:0] hit_code;
   estado_t    estado;

   assign p = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

   sincronizador_2ff #(
      .WIDTH   (SEG_W),
      .RST_VAL (PAT_BLANK)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (p),
      .q     (sync2)
   );

   assign hit_code = pat_to_code(cand);

   // TRAVADO after reset so the blank reset image is never reported.
   always_ff @(posedge clk) begin
      if (reset) begin
         cand      <= PAT_BLANK;
         cnt       <= 8'd0;
         estado    <= TRAVADO;
         {A, B, C} <= 3'b000;
         valido    <= 1'b0;
         erro      <= 1'b0;
      end else begin
         valido <= 1'b0;
         erro   <= 1'b0;
         if (sync2 != cand) begin
            cand   <= sync2;
            cnt    <= 8'd1;
            estado <= ESPERA;
         end else if (estado == ESPERA && cnt == CNT_MAX) begin
            estado <= TRAVADO;
            if (hit_code[3]) begin
               {A, B, C} <= hit_code[2:0];
               valido    <= 1'b1;
            end else if (cand != PAT_BLANK) begin
               erro <= 1'b1;
            end
         end else if (estado == ESPERA) begin
            cnt <= cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_cod_numero_linha.sv
// Bench for cod_numero_linha: directed scenarios plus random holds,
// compared every cycle against a run-length reference model.
module tb_cod_numero_linha;

   localparam int          S     = 4;
   localparam logic [6:0]  BLANK = 7'b1111111;
   localparam int          INF   = 100000;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] p = BLANK;
   logic       A, B, C, valido, erro;

   always #5 clk = ~clk;

   cod_numero_linha #(.STABLE_CYCLES(S)) dut (
      .clk    (clk),
      .reset  (reset),
      .seg_a  (p[6]),
      .seg_b  (p[5]),
      .seg_c  (p[4]),
      .seg_d  (p[3]),
      .seg_e  (p[2]),
      .seg_f  (p[1]),
      .seg_g  (p[0]),
      .A      (A),
      .B      (B),
      .C      (C),
      .valido (valido),
      .erro   (erro)
   );

   logic [6:0] tab [8] = '{7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000,
                           7'b0001111, 7'b0000000};

   int n_tests = 0;
   int n_fail  = 0;
   int n_val   = 0;
   int n_err   = 0;

   logic [6:0] s_hist [$];
   bit         r_hist [$];
   logic [6:0] m_v   = BLANK;
   int         m_run = INF;
   logic [2:0] m_abc = 3'b000;
   bit         m_val = 1'b0;
   bit         m_err = 1'b0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Filter sees the pattern sampled two edges earlier (blank across
   // a reset); a capture happens when a run reaches S+1 samples.
   task automatic model_edge();
      logic [6:0] f;
      int         n;
      int         hit;
      s_hist.push_back(reset ? BLANK : p);
      r_hist.push_back(reset);
      if (s_hist.size() > 3) begin
         void'(s_hist.pop_front());
         void'(r_hist.pop_front());
      end
      n     = s_hist.size() - 1;
      m_val = 1'b0;
      m_err = 1'b0;
      if (r_hist[n]) begin
         m_v   = BLANK;
         m_run = INF;
         m_abc = 3'b000;
         return;
      end
      if (n < 2 || r_hist[n-1]) f = BLANK;
      else                      f = s_hist[n-2];
      if (f == m_v) begin
         if (m_run < INF) m_run++;
      end else begin
         m_v   = f;
         m_run = 1;
      end
      if (m_run == S + 1) begin
         hit = -1;
         for (int i = 0; i < 8; i++)
            if (tab[i] == f) hit = i;
         if (hit >= 0) begin
            m_abc = 3'(hit);
            m_val = 1'b1;
         end else if (f != BLANK) begin
            m_err = 1'b1;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("valido", valido, m_val);
      check("erro", erro, m_err);
      check("abc", {A, B, C}, m_abc);
      check("excl", valido & erro, 0);
      n_val += int'(valido);
      n_err += int'(erro);
   endtask

   task automatic hold(input logic [6:0] pat, input int cyc);
      p = pat;
      repeat (cyc) step();
   endtask

   initial begin
      int len;
      int kind;
      reset = 1'b1;
      p     = BLANK;
      repeat (3) step();
      check("rst_abc", {A, B, C}, 3'b000);
      check("rst_strobe", {valido, erro}, 2'b00);
      reset = 1'b0;

      // 1: latency of first capture
      p = tab[0];
      n_val = 0;
      n_err = 0;
      for (int i = 1; i <= 10; i++) begin
         step();
         check("t1_lat", valido, (i == S + 3) ? 1 : 0);
      end
      check("t1_cnt", n_val, 1);
      check("t1_err", n_err, 0);
      check("t1_abc", {A, B, C}, 3'b000);

      // 2: sweep
      hold(BLANK, 10);
      n_val = 0;
      for (int c = 0; c < 8; c++) begin
         hold(tab[c], 10);
         check("t2_abc", {A, B, C}, c);
      end
      check("t2_cnt", n_val, 8);

      // 3: glitches shorter than the window
      n_val = 0;
      hold(7'b0000110, 3);
      hold(7'b0010010, 2);
      check("t3_glitch", n_val, 0);
      hold(7'b0000110, 10);
      check("t3_cnt", n_val, 1);
      check("t3_abc", {A, B, C}, 3'b010);

      // 4: unknown pattern
      hold(7'b1001100, 10);
      n_val = 0;
      n_err = 0;
      hold(7'b1111110, 10);
      check("t4_err", n_err, 1);
      check("t4_val", n_val, 0);
      check("t4_abc", {A, B, C}, 3'b011);

      // 5: blank, then reset mid-count
      n_val = 0;
      n_err = 0;
      hold(BLANK, 10);
      hold(7'b0100000, 3);
      reset = 1'b1;
      step();
      reset = 1'b0;
      p = BLANK;
      step();
      check("t5_abc", {A, B, C}, 3'b000);
      hold(BLANK, 8);
      check("t5_cnt", n_val + n_err, 0);

      // 6: long hold gives one strobe, revisit gives another
      n_val = 0;
      hold(7'b0001111, 100);
      check("t6_one", n_val, 1);
      check("t6_abc", {A, B, C}, 3'b110);
      hold(BLANK, 10);
      hold(7'b0001111, 10);
      check("t6_two", n_val, 2);

      // random holds, occasional resets
      for (int it = 0; it < 300; it++) begin
         kind = int'($urandom_range(0, 9));
         len  = int'($urandom_range(1, 12));
         if (kind < 6)       p = tab[$urandom_range(0, 7)];
         else if (kind < 8)  p = BLANK;
         else                p = 7'($urandom);
         if ($urandom_range(0, 19) == 0) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
         end
         repeat (len) step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
